cpu_clk_ctrl: RTL and testbench
===============================

Name: cpu_clk_ctrl

Overview:
- Execution controller for the pipelined MIPS core on the FPGA board.
- Produces a single-cycle clock-enable `cpu_en` on the fast board clock. The CPU registers advance only when `cpu_en` is high; no derived clocks are used.
- Supports four modes: halt, free-run at a divided rate, single-step from a push button, and N-cycle burst.
- Halts on a PC breakpoint. Sits between the board buttons/switches and the CPU core.

Parameters:
- DIV, 100000000: fast-clock cycles per enable pulse in RUN/BURST. Must be ≥ 2.
- DEB_CYCLES, 1000000: consecutive stable samples required before the debounced button level changes.
- PCW, 32: PC / breakpoint address width.

Ports:
- clk  in  1  board clock
- rst  in  1  synchronous reset, active-high
- mode  in  2  00 HALT, 01 RUN, 10 STEP, 11 BURST
- step_btn  in  1  raw asynchronous push button, active-high
- burst_len  in  8  pulses per burst, sampled at burst start
- bp_en  in  1  breakpoint enable
- bp_addr  in  PCW  breakpoint address
- pc  in  PCW  current CPU PC
- cpu_en  out  1  CPU advance enable, one clk wide
- halted  out  1  high in S_HALT or S_BP
- bp_hit  out  1  high in S_BP
- cycle_count  out  32  number of cpu_en pulses issued
- state  out  3  current FSM state, for debug LEDs

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=S_HALT; mode_q=00.
  - Tick counter, burst remaining count, debounce counter, synchronizer FFs and debounced level all 0.
  - cpu_en=0, cycle_count=0, halted=1, bp_hit=0.
  - Reset has priority over everything else.
- Button path:
  - step_btn passes through a 2-FF synchronizer.
  - Debouncer: if the synced value ≠ debounced level, count up; when the count reaches DEB_CYCLES-1, flip the level and clear the count. If the synced value = level, clear the count.
  - step_req is a 1-cycle pulse on the debounced rising edge only. Release generates nothing.
- Tick counter:
  - Counts 0..DIV-1 only in S_RUN and S_BURST_ACT; held at 0 in all other states.
  - tick = (counter == DIV-1); the counter wraps to 0 on tick.
- Mode change:
  - mode_q <= mode every cycle.
  - When mode ≠ mode_q, move to the entry state for the new mode: HALT→S_HALT, RUN→S_RUN, STEP→S_STEP, BURST→S_BURST_IDLE.
  - On that transition, clear the tick counter and burst remaining count; no cpu_en that cycle.
  - Mode change overrides tick, step_req and breakpoint events in the same cycle.
- States (encoding 0..5):
  - S_HALT: no pulses.
  - S_RUN: on tick, if bp_en && pc == bp_addr, go to S_BP with no pulse; else assert cpu_en.
  - S_STEP: on step_req assert cpu_en. No breakpoint check.
  - S_BURST_IDLE: on step_req with burst_len ≠ 0, load remaining=burst_len and go to S_BURST_ACT. burst_len=0 is ignored.
  - S_BURST_ACT: on tick, perform the breakpoint check as in S_RUN. Otherwise assert cpu_en and decrement remaining; after the pulse that takes remaining to 0, go to S_BURST_IDLE. step_req is ignored here.
  - S_BP: no pulses. On step_req, assert cpu_en once with no breakpoint check, then return to S_RUN (mode RUN) or S_BURST_IDLE (mode BURST), with the tick counter cleared.
- cpu_en timing:
  - Registered; high for exactly the one clk cycle following the edge at which the triggering tick or step_req was seen.
  - Never high on consecutive cycles.
- cycle_count: +1 on every cpu_en pulse; wraps modulo 2^32.
- Breakpoint compare: pc is sampled at the tick cycle, so the CPU stops before executing the instruction at bp_addr.

Test Plan (DIV=4, DEB_CYCLES=3, PCW=32):
1. Reset, then mode=01 held for 40 clk → cpu_en pulses 1 clk wide, exactly 4 clk apart; the first pulse comes 4–5 clk after entering S_RUN. cycle_count equals the pulse count (9–10). halted=0.
2. mode=10; step_btn bounces 1,0,1,0 on alternate cycles, then held 1 for 10 clk, then 0 → exactly one cpu_en pulse, cycle_count +1. Release gives no pulse. A glitch of 2 cycles gives no pulse.
3. mode=11, burst_len=3, one clean press → 3 pulses 4 clk apart, then state=S_BURST_IDLE. A second press with burst_len=0 → no pulses.
4. mode=01, bp_en=1, bp_addr=0x0000000C, bench increments pc by 4 per cpu_en starting at 0 → pulses at pc=0, 4, 8, then halted=1, bp_hit=1, pc=0xC, cycle_count=3. One press → one pulse, pc=0x10, back in S_RUN, pulses resume.
5. Mid-burst (remaining=2), mode switched to 00 → no further cpu_en, state=S_HALT. Back to 11 → state=S_BURST_IDLE, no pulses until a new press.
6. Mid-run, assert rst for 1 clk → next cycle: cpu_en=0, cycle_count=0, state=S_HALT, halted=1. With mode still 01, state=S_RUN one cycle later.

Source files
------------

// File: rtl/cpu_clk_ctrl_if.sv
// cpu_clk_ctrl_if: control/status bundle between the board-side controller
// (buttons, switches, CPU PC tap) and the cpu_clk_ctrl execution controller.
//   master : drives mode, step_btn, burst_len, bp_en, bp_addr, pc;
//            observes cpu_en, halted, bp_hit, cycle_count, state
//   slave  : the controller itself (mirror of master)
interface cpu_clk_ctrl_if #(
    parameter int PCW = 32
);
    logic [1:0]     mode;        // 00 HALT, 01 RUN, 10 STEP, 11 BURST
    logic           step_btn;    // raw asynchronous push button, active-high
    logic [7:0]     burst_len;   // pulses per burst, sampled at burst start
    logic           bp_en;       // breakpoint enable
    logic [PCW-1:0] bp_addr;     // breakpoint address
    logic [PCW-1:0] pc;          // current CPU PC
    logic           cpu_en;      // one-clk CPU advance enable
    logic           halted;      // in S_HALT or S_BP
    logic           bp_hit;      // in S_BP
    logic [31:0]    cycle_count; // cpu_en pulses issued (wraps)
    logic [2:0]     state;       // FSM state for debug LEDs

    modport master (
        output mode, step_btn, burst_len, bp_en, bp_addr, pc,
        input  cpu_en, halted, bp_hit, cycle_count, state
    );

    modport slave (
        input  mode, step_btn, burst_len, bp_en, bp_addr, pc,
        output cpu_en, halted, bp_hit, cycle_count, state
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: execution controller for the pipelined MIPS core.
// Generates a one-clk clock-enable (cpu_en) on the board clock in one of
// four modes (halt, divided free-run, push-button single step, N-pulse
// burst) and stops on a PC breakpoint.
// Ports:
//   clk  - board clock
//   rst  - synchronous reset, active-high
//   bus  - cpu_clk_ctrl_if.slave (mode/button/breakpoint inputs,
//          cpu_en/halted/bp_hit/cycle_count/state outputs)
module cpu_clk_ctrl #(
    parameter int DIV        = 100000000,
    parameter int DEB_CYCLES = 1000000,
    parameter int PCW        = 32
) (
    input  logic           clk,
    input  logic           rst,
    cpu_clk_ctrl_if.slave  bus
);

    localparam int CW = $clog2(DIV);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_HALT       = 3'd0,
        S_RUN        = 3'd1,
        S_STEP       = 3'd2,
        S_BURST_IDLE = 3'd3,
        S_BURST_ACT  = 3'd4,
        S_BP         = 3'd5
    } state_t;

    state_t          r_state, w_nstate;
    logic [1:0]      r_mode_q;
    logic [CW-1:0]   r_tick_cnt, w_tick_nxt;
    logic [7:0]      r_rem, w_rem;
    logic            r_sync1, r_sync2;
    logic [DW-1:0]   r_deb_cnt;
    logic            r_deb_lvl;
    logic            r_step_req;
    logic            r_cpu_en, w_en;
    logic [31:0]     r_cycle_cnt;

    logic            w_counting, w_tick, w_bp, w_mode_chg;

    // ---------------- button path: 2-FF sync, debounce, rising edge ----------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_deb_cnt  <= '0;
            r_deb_lvl  <= 1'b0;
            r_step_req <= 1'b0;
        end else begin
            r_sync1    <= bus.step_btn;
            r_sync2    <= r_sync1;
            r_step_req <= 1'b0;
            if (r_sync2 != r_deb_lvl) begin
                if (r_deb_cnt == DW'(DEB_CYCLES - 1)) begin
                    r_deb_lvl  <= ~r_deb_lvl;
                    r_deb_cnt  <= '0;
                    // only the 0->1 flip requests a step; release is silent
                    r_step_req <= ~r_deb_lvl;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    // ---------------- tick / event decode -----------------------------------
    assign w_counting = (r_state == S_RUN) || (r_state == S_BURST_ACT);
    assign w_tick     = w_counting && (r_tick_cnt == CW'(DIV - 1));
    assign w_bp       = bus.bp_en && (bus.pc == bus.bp_addr);
    assign w_mode_chg = (bus.mode != r_mode_q);

    // ---------------- next-state / outputs ----------------------------------
    always_comb begin
        w_nstate = r_state;
        w_en     = 1'b0;
        w_rem    = r_rem;
        // counter only runs in the two pulsing states; a tick wraps it and
        // any mode change restarts the period from zero
        if (w_mode_chg || !w_counting || w_tick)
            w_tick_nxt = '0;
        else
            w_tick_nxt = r_tick_cnt + 1'b1;

        if (w_mode_chg) begin
            // mode change wins over tick, step_req and breakpoint
            w_rem = 8'd0;
            case (bus.mode)
                2'b00:   w_nstate = S_HALT;
                2'b01:   w_nstate = S_RUN;
                2'b10:   w_nstate = S_STEP;
                default: w_nstate = S_BURST_IDLE;
            endcase
        end else begin
            case (r_state)
                S_HALT: ;
                S_RUN: begin
                    if (w_tick) begin
                        if (w_bp) w_nstate = S_BP;
                        else      w_en     = 1'b1;
                    end
                end
                S_STEP: begin
                    if (r_step_req) w_en = 1'b1;
                end
                S_BURST_IDLE: begin
                    if (r_step_req && (bus.burst_len != 8'd0)) begin
                        w_rem    = bus.burst_len;
                        w_nstate = S_BURST_ACT;
                    end
                end
                S_BURST_ACT: begin
                    if (w_tick) begin
                        if (w_bp) begin
                            w_nstate = S_BP;
                            w_rem    = 8'd0;
                        end else begin
                            w_en  = 1'b1;
                            w_rem = r_rem - 8'd1;
                            if (r_rem == 8'd1) w_nstate = S_BURST_IDLE;
                        end
                    end
                end
                S_BP: begin
                    // step past the breakpoint without re-checking it
                    if (r_step_req) begin
                        w_en     = 1'b1;
                        w_rem    = 8'd0;
                        w_nstate = (r_mode_q == 2'b11) ? S_BURST_IDLE : S_RUN;
                    end
                end
                default: w_nstate = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_HALT;
            r_mode_q    <= 2'b00;
            r_tick_cnt  <= '0;
            r_rem       <= 8'd0;
            r_cpu_en    <= 1'b0;
            r_cycle_cnt <= 32'd0;
        end else begin
            r_state    <= w_nstate;
            r_mode_q   <= bus.mode;
            r_tick_cnt <= w_tick_nxt;
            r_rem      <= w_rem;
            r_cpu_en   <= w_en;
            if (w_en) r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign bus.cpu_en      = r_cpu_en;
    assign bus.halted      = (r_state == S_HALT) || (r_state == S_BP);
    assign bus.bp_hit      = (r_state == S_BP);
    assign bus.cycle_count = r_cycle_cnt;
    assign bus.state       = r_state;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
module tb_cpu_clk_ctrl;
    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int PCW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_clk_ctrl_if #(.PCW(PCW)) bus ();

    cpu_clk_ctrl #(.DIV(DIV), .DEB_CYCLES(DEB), .PCW(PCW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc_no = 0;
    bit pc_auto = 1'b0;
    int pulse_cyc[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ---------------------------------------
    // Described in terms of sample histories: the synced button is the input
    // from two edges ago, the debounced level flips after DEB consecutive
    // disagreeing samples, and ticks fall every DIV-th edge spent pulsing.
    // State codes: 0 HALT 1 RUN 2 STEP 3 BURST_IDLE 4 BURST_ACT 5 BP;
    // the entry state for mode m is simply code m.
    int          m_st, m_mq, m_age, m_rem, m_lvl, m_req, m_en;
    logic [31:0] m_cnt;
    logic        m_bq[$];
    logic        m_win[$];

    task automatic m_step();
        logic syn;
        bit   all_diff, tick, bp;
        if (rst) begin
            m_st = 0; m_mq = 0; m_age = 0; m_rem = 0;
            m_lvl = 0; m_req = 0; m_en = 0; m_cnt = 32'd0;
            m_bq.delete(); m_bq.push_back(1'b0); m_bq.push_back(1'b0);
            m_win.delete();
            return;
        end
        syn = m_bq.pop_front();
        m_bq.push_back(bus.step_btn);
        m_win.push_back(syn);
        if (m_win.size() > DEB) void'(m_win.pop_front());
        all_diff = (m_win.size() == DEB);
        foreach (m_win[i]) if (int'(m_win[i]) == m_lvl) all_diff = 1'b0;

        tick = (m_st == 1 || m_st == 4) && (m_age % DIV == DIV - 1);
        bp   = bus.bp_en && (bus.pc == bus.bp_addr);
        m_en = 0;
        if (int'(bus.mode) != m_mq) begin
            m_st = int'(bus.mode); m_rem = 0; m_age = 0;
        end else begin
            if (m_st == 1 || m_st == 4) m_age++; else m_age = 0;
            case (m_st)
                1: if (tick) begin if (bp) m_st = 5; else m_en = 1; end
                2: if (m_req != 0) m_en = 1;
                3: if (m_req != 0 && bus.burst_len != 0) begin
                       m_rem = int'(bus.burst_len); m_st = 4;
                   end
                4: if (tick) begin
                       if (bp) m_st = 5;
                       else begin
                           m_en = 1; m_rem--;
                           if (m_rem == 0) m_st = 3;
                       end
                   end
                5: if (m_req != 0) begin m_en = 1; m_st = (m_mq == 3) ? 3 : 1; end
                default: ;
            endcase
        end
        m_req = (all_diff && m_lvl == 0) ? 1 : 0;
        if (all_diff) begin m_lvl = 1 - m_lvl; m_win.delete(); end
        m_cnt = m_cnt + 32'(m_en);
        m_mq  = int'(bus.mode);
    endtask

    // one clock: model steps at the edge, outputs compared on the falling edge
    task automatic cyc();
        cyc_no++;
        @(posedge clk);
        m_step();
        @(negedge clk);
        chk("cpu_en",      64'(bus.cpu_en),      64'(m_en));
        chk("halted",      64'(bus.halted),      64'(m_st == 0 || m_st == 5));
        chk("bp_hit",      64'(bus.bp_hit),      64'(m_st == 5));
        chk("state",       64'(bus.state),       64'(m_st));
        chk("cycle_count", 64'(bus.cycle_count), 64'(m_cnt));
        if (bus.cpu_en) begin
            pulse_cyc.push_back(cyc_no);
            if (pc_auto) bus.pc = bus.pc + 32'd4;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); rst = 1'b0;
    endtask

    task automatic press(input int hold);
        bus.step_btn = 1'b1; run(hold);
        bus.step_btn = 1'b0; run(10);
    endtask

    task automatic wait_en(input string tag, input int budget);
        int k = 0;
        do begin cyc(); k++; end while (!bus.cpu_en && k < budget);
        chk(tag, 64'(bus.cpu_en), 64'd1);
    endtask

    initial begin
        int c, c0, bad, btn_left;
        bus.mode = 2'b00; bus.step_btn = 1'b0; bus.burst_len = 8'd0;
        bus.bp_en = 1'b0; bus.bp_addr = '0; bus.pc = '0;

        // reset state
        do_reset();
        chk("rst_state",  64'(bus.state),       64'd0);
        chk("rst_halted", 64'(bus.halted),      64'd1);
        chk("rst_cc",     64'(bus.cycle_count), 64'd0);

        // 1: free run
        bus.mode = 2'b01; c0 = cyc_no; pulse_cyc.delete();
        run(40);
        chk("t1_npulse", 64'(pulse_cyc.size()), 64'd9);
        bad = 0;
        for (int i = 1; i < pulse_cyc.size(); i++)
            if (pulse_cyc[i] - pulse_cyc[i-1] != 4) bad++;
        chk("t1_gap", 64'(bad), 64'd0);
        if (pulse_cyc.size() > 0)
            chk("t1_first", 64'(pulse_cyc[0] - (c0 + 1) inside {4, 5}), 64'd1);
        chk("t1_cc",     64'(bus.cycle_count), 64'(pulse_cyc.size()));
        chk("t1_halted", 64'(bus.halted), 64'd0);

        // 2: step with bouncing button, release, short glitch
        bus.mode = 2'b10; run(3);
        c = int'(bus.cycle_count);
        for (int i = 0; i < 4; i++) begin bus.step_btn = (i % 2 == 0); cyc(); end
        bus.step_btn = 1'b1; run(10);
        bus.step_btn = 1'b0; run(10);
        chk("t2_one", 64'(bus.cycle_count), 64'(c + 1));
        bus.step_btn = 1'b1; run(2);
        bus.step_btn = 1'b0; run(10);
        chk("t2_glitch", 64'(bus.cycle_count), 64'(c + 1));

        // 3: burst of 3, then zero-length burst ignored
        bus.mode = 2'b11; bus.burst_len = 8'd3; run(3);
        c = int'(bus.cycle_count); pulse_cyc.delete();
        press(6); run(15);
        chk("t3_burst", 64'(bus.cycle_count), 64'(c + 3));
        chk("t3_idle",  64'(bus.state), 64'd3);
        bad = 0;
        for (int i = 1; i < pulse_cyc.size(); i++)
            if (pulse_cyc[i] - pulse_cyc[i-1] != 4) bad++;
        chk("t3_gap", 64'(bad), 64'd0);
        bus.burst_len = 8'd0;
        press(6); run(10);
        chk("t3_zero", 64'(bus.cycle_count), 64'(c + 3));

        // 4: breakpoint at 0xC, step past it, run resumes
        bus.pc = '0; pc_auto = 1'b1;
        do_reset();
        bus.bp_en = 1'b1; bus.bp_addr = 32'h0000_000C; bus.mode = 2'b01;
        for (int k = 0; k < 60 && !bus.bp_hit; k++) cyc();
        chk("t4_bp_hit", 64'(bus.bp_hit), 64'd1);
        chk("t4_halted", 64'(bus.halted), 64'd1);
        chk("t4_pc",     64'(bus.pc), 64'h0C);
        chk("t4_cc",     64'(bus.cycle_count), 64'd3);
        bus.step_btn = 1'b1;
        wait_en("t4_step_pulse", 20);
        chk("t4_pc_step", 64'(bus.pc), 64'h10);
        cyc();
        chk("t4_run", 64'(bus.state), 64'd1);
        bus.step_btn = 1'b0; run(12);
        chk("t4_resume", 64'(bus.cycle_count >= 32'd5), 64'd1);
        bus.bp_en = 1'b0; pc_auto = 1'b0;

        // 5: leave a burst midway, come back idle
        do_reset();
        bus.mode = 2'b11; bus.burst_len = 8'd3; run(3);
        bus.step_btn = 1'b1;
        wait_en("t5_first", 30);
        bus.step_btn = 1'b0; bus.mode = 2'b00;
        c = int'(bus.cycle_count);
        run(20);
        chk("t5_halt_cc", 64'(bus.cycle_count), 64'(c));
        chk("t5_halt_st", 64'(bus.state), 64'd0);
        bus.mode = 2'b11; run(20);
        chk("t5_idle_st", 64'(bus.state), 64'd3);
        chk("t5_idle_cc", 64'(bus.cycle_count), 64'(c));

        // 6: reset in the middle of a run
        bus.mode = 2'b01; run(11);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("t6_en",     64'(bus.cpu_en), 64'd0);
        chk("t6_cc",     64'(bus.cycle_count), 64'd0);
        chk("t6_state",  64'(bus.state), 64'd0);
        chk("t6_halted", 64'(bus.halted), 64'd1);
        cyc();
        chk("t6_run", 64'(bus.state), 64'd1);

        // randomized soak against the model
        pc_auto = 1'b1; bus.pc = '0; btn_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) bus.mode = 2'($urandom_range(0, 3));
            if (btn_left == 0) begin
                bus.step_btn = 1'($urandom_range(0, 1));
                btn_left = $urandom_range(1, 8);
            end else btn_left--;
            if ($urandom_range(0, 99) < 5) bus.burst_len = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 99) < 3) bus.bp_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 3) bus.bp_addr = 32'($urandom_range(0, 7) * 4);
            if (bus.pc >= 32'd32) bus.pc = '0;
            if ($urandom_range(0, 999) < 3) begin
                rst = 1'b1; cyc(); rst = 1'b0;
            end else cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
